// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, mid-bit sampling, valid/framing-error strobes
// Revision: 1.0
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       active,
  output logic [2:0] rx_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RECEIVE = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [11:0] HALF_CNT = 12'((CLKS_PER_BIT - 1) / 2);
  localparam logic [11:0] LAST_CNT = 12'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic        rx_meta, rx_s;
  logic [11:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift_reg, shift_reg_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, framing_err_nxt, active_nxt;

  // Synchroniser resets to the idle-line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_reg_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      framing_err <= framing_err_nxt;
      active      <= active_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    clk_cnt_nxt     = clk_cnt;
    bit_idx_nxt     = bit_idx;
    shift_reg_nxt   = shift_reg;
    data_nxt        = data;
    valid_nxt       = 1'b0;
    framing_err_nxt = 1'b0;
    active_nxt      = active;

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        active_nxt  = 1'b0;
        if (!rx_s) begin
          state_nxt  = START;
          active_nxt = 1'b1;
        end
      end
      START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = RECEIVE;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_nxt  = IDLE;
            active_nxt = 1'b0;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 12'd1;
        end
      end
      RECEIVE: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt            = '0;
          shift_reg_nxt[bit_idx] = rx_s;
          if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
          end else begin
            bit_idx_nxt = '0;
            state_nxt   = STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 12'd1;
        end
      end
      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt = '0;
          active_nxt  = 1'b0;
          state_nxt   = CLEANUP;
          if (rx_s) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
          end else begin
            framing_err_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 12'd1;
        end
      end
      CLEANUP: begin
        // Wait for the line to go high so a held break cannot re-trigger.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        active_nxt = 1'b0;
      end
    endcase
  end

  assign rx_state = state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx at 16 clocks per bit
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       active;
  logic [2:0] rx_state;

  int tests;
  int fails;

  // Strobe observations, sampled on the falling edge.
  int         valid_cnt;
  int         ferr_cnt;
  int         both_cnt;
  int         wide_cnt;
  logic       prev_valid;
  logic [7:0] last_data;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .active      (active),
    .rx_state    (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_data = data;
      if (prev_valid === 1'b1) wide_cnt = wide_cnt + 1;
    end
    if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (valid === 1'b1 && framing_err === 1'b1) both_cnt = both_cnt + 1;
    prev_valid = valid;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", framing_err); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got=%b exp=0", active); end
    tests++; if (rx_state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", rx_state); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (5 * CPB) @(negedge clk);
        tests++; if (active !== 1'b1) begin fails++; $display("FAIL basic_active_mid got=%b exp=1", active); end
        tests++; if (rx_state !== 3'd2) begin fails++; $display("FAIL basic_state_mid got=%0d exp=2", rx_state); end
      end
    join
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL basic_active_end got=%b exp=0", active); end
    idle(20);
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL basic_valid_cnt got=%0d exp=1", valid_cnt - v0); end
    tests++; if (last_data !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", last_data); end
    tests++; if (data !== 8'hA5) begin fails++; $display("FAIL basic_data_hold got=%h exp=a5", data); end
    tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL basic_ferr_cnt got=%0d exp=0", ferr_cnt - f0); end
    tests++; if (wide_cnt !== 0) begin fails++; $display("FAIL basic_valid_width got=%0d wide exp=0", wide_cnt); end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h00, 1'b1);
    tests++; if (last_data !== 8'h00) begin fails++; $display("FAIL b2b_first_data got=%h exp=00", last_data); end
    send_byte(8'hFF, 1'b1);
    idle(20);
    tests++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_valid_cnt got=%0d exp=2", valid_cnt - v0); end
    tests++; if (last_data !== 8'hFF) begin fails++; $display("FAIL b2b_second_data got=%h exp=ff", last_data); end
    tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL b2b_ferr_cnt got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (rx_state !== 3'd1) begin fails++; $display("FAIL glitch_start_state got=%0d exp=1", rx_state); end
    idle(3 * CPB);
    tests++; if (rx_state !== 3'd0) begin fails++; $display("FAIL glitch_idle_state got=%0d exp=0", rx_state); end
    tests++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
      fails++; $display("FAIL glitch_strobes got valid=%0d ferr=%0d exp 0/0", valid_cnt - v0, ferr_cnt - f0);
    end
    tests++; if (data !== 8'hFF) begin fails++; $display("FAIL glitch_data got=%h exp=ff", data); end
  endtask

  task automatic test_framing();
    int v0, f0;
    send_byte(8'h3C, 1'b1);
    idle(20);
    tests++; if (data !== 8'h3C) begin fails++; $display("FAIL frame_good_data got=%h exp=3c", data); end
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h81, 1'b0);
    idle(2 * CPB);
    tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL frame_ferr_cnt got=%0d exp=1", ferr_cnt - f0); end
    tests++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL frame_valid_cnt got=%0d exp=0", valid_cnt - v0); end
    tests++; if (data !== 8'h3C) begin fails++; $display("FAIL frame_data_hold got=%h exp=3c", data); end
    v0 = valid_cnt;
    send_byte(8'h42, 1'b1);
    idle(20);
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL frame_recover_valid got=%0d exp=1", valid_cnt - v0); end
    tests++; if (data !== 8'h42) begin fails++; $display("FAIL frame_recover_data got=%h exp=42", data); end
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL frame_both_strobes got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_break();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL break_ferr_cnt got=%0d exp=1", ferr_cnt - f0); end
    tests++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL break_valid_cnt got=%0d exp=0", valid_cnt - v0); end
    tests++; if (rx_state !== 3'd4) begin fails++; $display("FAIL break_state_held got=%0d exp=4", rx_state); end
    idle(6);
    tests++; if (rx_state !== 3'd0) begin fails++; $display("FAIL break_state_release got=%0d exp=0", rx_state); end
    idle(20);
  endtask

  task automatic test_reset_midframe();
    int v0, f0;
    fork
      send_byte(8'h0F, 1'b1);
      begin
        repeat (5 * CPB + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL rstmid_data got=%h exp=00", data); end
        tests++; if (active !== 1'b0 || valid !== 1'b0 || framing_err !== 1'b0) begin
          fails++; $display("FAIL rstmid_flags got active=%b valid=%b ferr=%b exp 0/0/0", active, valid, framing_err);
        end
        tests++; if (rx_state !== 3'd0) begin fails++; $display("FAIL rstmid_state got=%0d exp=0", rx_state); end
      end
    join
    v0 = valid_cnt; f0 = ferr_cnt;
    idle(4);
    rst_n = 1'b1;
    idle(3 * CPB);
    tests++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
      fails++; $display("FAIL rstmid_no_strobe got valid=%0d ferr=%0d exp 0/0", valid_cnt - v0, ferr_cnt - f0);
    end
    send_byte(8'h5A, 1'b1);
    idle(20);
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL rstmid_valid_cnt got=%0d exp=1", valid_cnt - v0); end
    tests++; if (data !== 8'h5A) begin fails++; $display("FAIL rstmid_data_after got=%h exp=5a", data); end
  endtask

  initial begin
    tests = 0; fails = 0;
    valid_cnt = 0; ferr_cnt = 0; both_cnt = 0; wide_cnt = 0;
    prev_valid = 1'b0; last_data = 8'h00;
    rst_n = 1'b0;
    rx = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_break();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
